// File: rtl/dsp_round_decim_if.sv
// rtl/dsp_round_decim_if.sv - sample-in / AXI-Stream-out bundle for the requantising decimator.
interface dsp_round_decim_if #(
   parameter int CH_NUM    = 2,
   parameter int IN_WIDTH  = 34,
   parameter int OUT_WIDTH = 16
);
   logic                               tvalid_i;
   logic [CH_NUM-1:0][IN_WIDTH-1:0]    tdata_i;
   logic                               tvalid_o;
   logic                               tready_i;
   logic [CH_NUM-1:0][OUT_WIDTH-1:0]   tdata_o;

   modport master (
      output tvalid_i, tdata_i, tready_i,
      input  tvalid_o, tdata_o
   );

   modport slave (
      input  tvalid_i, tdata_i, tready_i,
      output tvalid_o, tdata_o
   );
endinterface

// File: rtl/dsp_round_decim.sv
// rtl/dsp_round_decim.sv - round-half-up, shift, saturate and decimate multichannel FIR output.
// Two-stage pipeline feeding a 2-entry output FIFO; the saturation stage writes the FIFO directly.
module dsp_round_decim #(
   parameter int CH_NUM    = 2,
   parameter int IN_WIDTH  = 34,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 17,
   parameter int DECIM     = 4
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                en_i,
   input  logic                clr_i,
   dsp_round_decim_if.slave    bus,
   output logic [CH_NUM-1:0]   ovf_o,
   output logic                drop_o
);
   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int RW   = IN_WIDTH + 1;
   localparam logic signed [RW-1:0] SAT_MAX = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] SAT_MIN = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef logic [CH_NUM-1:0][OUT_WIDTH-1:0] word_t;

   logic [PH_W-1:0]       phase;
   logic                  accept;
   logic                  keep;
   logic signed [RW-1:0]  rnd  [CH_NUM];
   logic signed [RW-1:0]  s1_r [CH_NUM];
   logic                  s1_vld;
   word_t                 sat;
   logic [CH_NUM-1:0]     clamp;
   word_t                 mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic                  full;
   logic                  pop;
   logic                  wr;

   assign accept = bus.tvalid_i && en_i;
   assign keep   = accept && (phase == '0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         phase <= '0;
      end else if (clr_i) begin
         phase <= '0;
      end else if (accept) begin
         phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
   end

   // One extra bit of headroom so adding the half-LSB never wraps.
   for (genvar c = 0; c < CH_NUM; c++) begin : g_rnd
      logic signed [RW-1:0] ext;
      assign ext = {bus.tdata_i[c][IN_WIDTH-1], bus.tdata_i[c]};
      if (SHIFT > 0) begin : g_sh
         localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
         assign rnd[c] = (ext + HALF) >>> SHIFT;
      end else begin : g_nosh
         assign rnd[c] = ext;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_vld <= 1'b0;
         for (int c = 0; c < CH_NUM; c++) s1_r[c] <= '0;
      end else begin
         s1_vld <= keep;
         if (keep) begin
            for (int c = 0; c < CH_NUM; c++) s1_r[c] <= rnd[c];
         end
      end
   end

   always_comb begin
      sat   = '0;
      clamp = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (s1_r[c] > SAT_MAX) begin
            sat[c]   = SAT_MAX[OUT_WIDTH-1:0];
            clamp[c] = 1'b1;
         end else if (s1_r[c] < SAT_MIN) begin
            sat[c]   = SAT_MIN[OUT_WIDTH-1:0];
            clamp[c] = 1'b1;
         end else begin
            sat[c]   = s1_r[c][OUT_WIDTH-1:0];
         end
      end
   end

   // When full, a write may only proceed if the head leaves in the same cycle.
   assign full = (count == 2'd2);
   assign pop  = (count != 2'd0) && bus.tready_i;
   assign wr   = s1_vld && (!full || pop);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= sat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, wr} - {1'b0, pop};
      end
   end

   assign bus.tvalid_o = (count != 2'd0);
   assign bus.tdata_o  = mem[rd_ptr];

   // A flag event in the same cycle as clr_i survives the clear.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ovf_o  <= '0;
         drop_o <= 1'b0;
      end else begin
         ovf_o  <= (clr_i ? '0 : ovf_o) | (s1_vld ? clamp : '0);
         drop_o <= (drop_o && !clr_i) || (s1_vld && full && !pop);
      end
   end
endmodule

// File: tb/tb_dsp_round_decim.sv
// tb/tb_dsp_round_decim.sv - scoreboard bench for dsp_round_decim at DECIM=1 and DECIM=4.
module tb_dsp_round_decim;
   logic            clk    = 1'b0;
   logic            rstn   = 1'b0;
   logic            en     = 1'b0;
   logic            clr    = 1'b0;
   logic            tvalid = 1'b0;
   logic            tready = 1'b1;
   logic [1:0][33:0] tdata = '0;

   logic             tvo   [2];
   logic [1:0][15:0] tdo   [2];
   logic [1:0]       ovfw  [2];
   logic             dropw [2];

   int n_chk  = 0;
   int n_pass = 0;
   longint got1[$];
   longint got4[$];

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic logic [15:0] requant(input longint x, output bit cl);
      longint r;
      r  = (x + 65536) >>> 17;
      cl = 1'b0;
      if (r > 32767) begin r = 32767; cl = 1'b1; end
      else if (r < -32768) begin r = -32768; cl = 1'b1; end
      return r[15:0];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int D = (g == 0) ? 1 : 4;

      dsp_round_decim_if #(.CH_NUM(2), .IN_WIDTH(34), .OUT_WIDTH(16)) bus ();
      assign bus.tvalid_i = tvalid;
      assign bus.tdata_i  = tdata;
      assign bus.tready_i = tready;
      assign tvo[g]       = bus.tvalid_o;
      assign tdo[g]       = bus.tdata_o;

      dsp_round_decim #(.CH_NUM(2), .IN_WIDTH(34), .OUT_WIDTH(16), .SHIFT(17), .DECIM(D)) dut (
         .clk_i (clk), .rstn_i(rstn), .en_i(en), .clr_i(clr),
         .bus   (bus), .ovf_o(ovfw[g]), .drop_o(dropw[g])
      );

      int          ph, cnt;
      bit          s1_v, pop_m, cb, m_drop;
      logic [31:0] s1_d;
      logic [1:0]  s1_c, m_ovf;
      logic [31:0] exp_q[$];

      // Reference: kept sample lands in a 2-deep queue one edge after acceptance.
      always @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            ph = 0; cnt = 0; s1_v = 0; m_ovf = '0; m_drop = 0;
            exp_q.delete();
         end else begin
            pop_m = (cnt > 0) && tready;
            if (clr) begin m_ovf = '0; m_drop = 0; end
            if (s1_v) begin
               m_ovf |= s1_c;
               if (cnt == 2 && !pop_m) m_drop = 1;
               else begin exp_q.push_back(s1_d); cnt++; end
            end
            if (pop_m) cnt--;
            s1_v = 0;
            if (en && tvalid) begin
               if (ph == 0) begin
                  s1_v = 1;
                  for (int c = 0; c < 2; c++) begin
                     s1_d[c*16 +: 16] = requant(longint'($signed(tdata[c])), cb);
                     s1_c[c] = cb;
                  end
               end
               ph = (ph + 1) % D;
            end
            if (clr) ph = 0;
         end
      end

      always @(negedge clk) begin
         if (rstn) begin
            check($sformatf("dec%0d tvalid_o", D), tvo[g], cnt != 0);
            if (tvo[g] && exp_q.size() > 0) check($sformatf("dec%0d tdata_o", D), tdo[g], exp_q[0]);
            check($sformatf("dec%0d ovf_o", D), ovfw[g], m_ovf);
            check($sformatf("dec%0d drop_o", D), dropw[g], m_drop);
            if (tvo[g] && tready && exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rstn && tready && tvo[0]) got1.push_back(longint'($signed(tdo[0][0])));
      if (rstn && tready && tvo[1]) got4.push_back(longint'($signed(tdo[1][0])));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input longint v);
      tdata[0] = v[33:0];
      tdata[1] = v[33:0];
      tvalid   = 1'b1;
      step();
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic check_list(input string nm, input longint got[$], input longint exp[$]);
      check({nm, " count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check($sformatf("%s[%0d]", nm, i), (i < got.size()) ? got[i] : -999999, exp[i]);
   endtask

   function automatic logic [33:0] rand_x();
      longint v;
      case ($urandom_range(0, 2))
         0: v = longint'({$urandom, $urandom});
         1: v = longint'($urandom_range(0, 1 << 24)) - (1 << 23);
         default: v = (longint'($urandom_range(0, 80000)) - 40000) * 131072
                      + ($urandom_range(0, 1) ? 65536 : 65535);
      endcase
      return v[33:0];
   endfunction

   longint t1_x[4] = '{458752, -65536, -65537, 65535};
   longint t1_e[4] = '{4, 0, -1, 0};

   initial begin
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      step();
      for (int g = 0; g < 2; g++) begin
         check("reset tvalid_o", tvo[g], 0);
         check("reset tdata_o", tdo[g], 0);
         check("reset ovf_o", ovfw[g], 0);
         check("reset drop_o", dropw[g], 0);
      end
      en = 1'b1;

      for (int i = 0; i < 4; i++) begin
         send(t1_x[i]);
         tvalid = 1'b0;
         step();
         check("round tvalid_o", tvo[0], 1);
         check($sformatf("round x=%0d", t1_x[i]), longint'($signed(tdo[0][0])), t1_e[i]);
         check("round ovf_o", ovfw[0], 0);
      end

      tdata[0] = 34'h1_FFFF_FFFF; tdata[1] = '0; tvalid = 1'b1; step();
      tvalid = 1'b0; step();
      check("sat max", longint'($signed(tdo[0][0])), 32767);
      check("sat ovf 01", ovfw[0], 2'b01);
      tdata[0] = '0; tdata[1] = 34'h2_0000_0000; tvalid = 1'b1; step();
      tvalid = 1'b0; step();
      check("sat min", longint'($signed(tdo[0][1])), -32768);
      check("sat ovf 11", ovfw[0], 2'b11);
      pulse_clr();
      check("clr ovf", ovfw[0], 0);

      got4.delete();
      for (int k = 1; k <= 9; k++) send(longint'(k) * 131072);
      tvalid = 1'b0;
      repeat (6) step();
      check_list("decim", got4, '{1, 5, 9});
      pulse_clr();
      got4.delete();
      for (int k = 1; k <= 9; k++) begin
         en = !(k == 3 || k == 4);
         send(longint'(k) * 131072);
      end
      en = 1'b1; tvalid = 1'b0;
      repeat (6) step();
      check_list("decim en gap", got4, '{1, 7});

      pulse_clr();
      tready = 1'b0; got1.delete();
      send(10 * 131072); send(20 * 131072); send(30 * 131072);
      tvalid = 1'b0;
      repeat (4) step();
      check("bp drop_o", dropw[0], 1);
      check("bp head", longint'($signed(tdo[0][0])), 10);
      repeat (3) step();
      check("bp head stable", longint'($signed(tdo[0][0])), 10);
      tready = 1'b1;
      repeat (4) step();
      check_list("bp out", got1, '{10, 20});

      pulse_clr();
      tready = 1'b0; got1.delete();
      send(10 * 131072); send(20 * 131072);
      tvalid = 1'b0;
      step();
      send(30 * 131072);
      tvalid = 1'b0; tready = 1'b1;
      step();
      check("full pop+write drop_o", dropw[0], 0);
      repeat (4) step();
      check_list("full pop+write out", got1, '{10, 20, 30});

      pulse_clr();
      tready = 1'b0; got1.delete(); got4.delete();
      send(5 * 131072); send(6 * 131072);
      tvalid = 1'b0;
      rstn = 1'b0;
      #1;
      check("async rst tvalid dec1", tvo[0], 0);
      check("async rst tvalid dec4", tvo[1], 0);
      step();
      rstn = 1'b1; tready = 1'b1;
      repeat (5) step();
      check("post-rst stale dec1", got1.size(), 0);
      check("post-rst stale dec4", got4.size(), 0);
      for (int k = 1; k <= 4; k++) send(longint'(k) * 131072);
      tvalid = 1'b0;
      repeat (6) step();
      check_list("post-rst phase", got4, '{1});

      for (int i = 0; i < 400; i++) begin
         tvalid   = ($urandom_range(0, 3) != 0);
         en       = ($urandom_range(0, 9) != 0);
         clr      = ($urandom_range(0, 49) == 0);
         tready   = ($urandom_range(0, 2) != 0);
         tdata[0] = rand_x();
         tdata[1] = rand_x();
         step();
      end
      tvalid = 1'b0; clr = 1'b0; en = 1'b1; tready = 1'b1;
      repeat (10) step();
      check("drain dec1", u[0].exp_q.size(), 0);
      check("drain dec4", u[1].exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
